send_game_event: RTL



---
 rtl/game_comm_pkg.sv | 20 ++
 rtl/send_game_event_if.sv | 23 ++
 rtl/uart_byte_handshake.sv | 80 ++++++++
 rtl/send_game_event.sv | 119 +++++++++++
 4 files changed

// File: rtl/game_comm_pkg.sv
// rtl/game_comm_pkg.sv - shared types, event codes and frame helpers for the game comm path
package game_comm_pkg;

  localparam logic [7:0] EV_DIFICULTY = 8'hAB;
  localparam logic [7:0] EV_BOARD     = 8'hB0;
  localparam logic [7:0] EV_VICTORY   = 8'hC5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_e;

  function automatic int frame_len(input int payload_bytes, input int checksum_en);
    return 1 + payload_bytes + ((checksum_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/send_game_event_if.sv
// rtl/send_game_event_if.sv - request side and UART byte handshake of the event sender
interface send_game_event_if #(
  parameter int PAYLOAD_BYTES = 1
);
  logic                       start;
  logic [8*PAYLOAD_BYTES-1:0] payload;
  logic                       tx_busy;
  logic [7:0]                 tx_data;
  logic                       tx_start;
  logic                       busy;
  logic                       data_sent;
  logic                       error;

  modport master (
    output start, payload, tx_busy,
    input  tx_data, tx_start, busy, data_sent, error
  );

  modport slave (
    input  start, payload, tx_busy,
    output tx_data, tx_start, busy, data_sent, error
  );
endinterface

// File: rtl/uart_byte_handshake.sv
// rtl/uart_byte_handshake.sv - sends one byte to the UART with tx_start/tx_busy handshake and ack timeout
module uart_byte_handshake
  import game_comm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_req_i,
  input  logic [7:0] byte_data_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  output logic       byte_done_o,
  output logic       byte_err_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [2:0] ST_IDLE      = 3'(IDLE);
  localparam logic [2:0] ST_SEND      = 3'(SEND);
  localparam logic [2:0] ST_WAIT_ACK  = 3'(WAIT_ACK);
  localparam logic [2:0] ST_WAIT_DONE = 3'(WAIT_DONE);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;

  assign byte_done_o = (state_q == ST_WAIT_DONE) && !tx_busy_i;
  assign byte_err_o  = (state_q == ST_WAIT_ACK) && !tx_busy_i && (cnt_q == CW'(ACK_TIMEOUT - 1));

  // A follow-on request arriving with byte_done goes straight back to SEND.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_req_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy_i) begin
          tx_data_d  = byte_data_i;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy_i)       state_d = ST_WAIT_DONE;
        else if (byte_err_o) state_d = ST_IDLE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_d = byte_req_i ? ST_SEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: rtl/send_game_event.sv
// rtl/send_game_event.sv - frames EVENT_CODE, payload bytes and optional XOR checksum into the UART
module send_game_event
  import game_comm_pkg::*;
#(
  parameter logic [7:0] EVENT_CODE    = EV_DIFICULTY,
  parameter int         PAYLOAD_BYTES = 1,
  parameter int         CHECKSUM_EN   = 1,
  parameter int         ACK_TIMEOUT   = 255
) (
  input logic              clk,
  input logic              reset,
  send_game_event_if.slave bus
);

  localparam int L  = frame_len(PAYLOAD_BYTES, CHECKSUM_EN);
  localparam int IW = $clog2(L);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_FRAME = 3'(SEND);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

  logic [2:0]                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic                       data_sent_q, data_sent_d;
  logic                       error_q, error_d;
  logic                       byte_req, byte_done, byte_err;
  logic [7:0]                 byte_data, csum, tx_data;
  logic                       tx_start;
  logic                       last_byte;

  assign last_byte = (idx_q == IW'(L - 1));

  always_comb begin
    csum = EVENT_CODE;
    for (int i = 0; i < PAYLOAD_BYTES; i++) csum = csum ^ payload_q[8*i +: 8];
  end

  // Index 0 is the event code, then payload MSB byte first, then the checksum.
  always_comb begin
    byte_data = EVENT_CODE;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (idx_q == IW'(i + 1)) byte_data = payload_q[8*(PAYLOAD_BYTES-1-i) +: 8];
    end
    if ((CHECKSUM_EN != 0) && (idx_q == IW'(L - 1))) byte_data = csum;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    payload_d   = payload_q;
    data_sent_d = 1'b0;
    error_d     = 1'b0;
    byte_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          payload_d = bus.payload;
          idx_d     = '0;
          byte_req  = 1'b1;
          state_d   = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (byte_err) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (byte_done) begin
          if (last_byte) begin
            data_sent_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            byte_req = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      payload_q   <= '0;
      data_sent_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      payload_q   <= payload_d;
      data_sent_q <= data_sent_d;
      error_q     <= error_d;
    end
  end

  uart_byte_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .clk        (clk),
    .reset      (reset),
    .byte_req_i (byte_req),
    .byte_data_i(byte_data),
    .tx_busy_i  (bus.tx_busy),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .byte_done_o(byte_done),
    .byte_err_o (byte_err)
  );

  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = tx_start;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.data_sent = data_sent_q;
  assign bus.error     = error_q;

endmodule
